noc_traffic_node: RTL and testbench
===================================

Name: noc_traffic_node

Overview:
- Synthesizable NoC endpoint. Replaces hand-written per-node stimulus and output-drain logic with one parametrised block per node.
- TX side: a packet generator that injects framed packets into a router local port.
- RX side: a packet sink/checker that drains the router local output and reports statistics and framing errors.
- Instantiated once per node (INDEX 0..N-1) around the NoC top level, for simulation and FPGA bring-up.

Parameters:
N, 6, number of nodes; destination field width DW = $clog2(N)
INDEX, 0, this node's id; checked against received head flits
DATA_WIDTH, 32, flit width
TYPE_WIDTH, 2, flit type field in bits [DATA_WIDTH-1 : DATA_WIDTH-TYPE_WIDTH]
FlitPerPacket, 6, flits per packet including head and tail (minimum 2)
COUNT_WIDTH, 16, width of packet counters and the gap field

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; starts a TX burst (sampled only in IDLE)
dest  input  DW  destination node of the burst
num_packets  input  COUNT_WIDTH  packets in the burst
gap_cycles  input  COUNT_WIDTH  idle cycles between packets
busy  output  1  TX burst in progress
done  output  1  one-cycle pulse after the last tail is accepted
data_out  output  DATA_WIDTH  TX flit to router data_in
valid_out  output  1  TX flit valid
ready_out  input  1  router ready for TX flit
data_in  input  DATA_WIDTH  RX flit from router data_out
valid_in  input  1  RX flit valid
ready_in  output  1  node ready to accept RX flit
clear_stats  input  1  zeroes RX counters and error flags
tx_packets  output  COUNT_WIDTH  packets fully sent
rx_packets  output  COUNT_WIDTH  well-formed packets received
rx_flits  output  COUNT_WIDTH  flits accepted
err_dest  output  1  sticky: head flit destination != INDEX
err_frame  output  1  sticky: framing violation
err_len  output  1  sticky: tail flit arrived at wrong packet length

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: every output is 0, except data_out = 0 and ready_in = 0 during rst. All FSMs go to their idle state and the payload counter is cleared.
- Flit type encoding: 1 = head, 2 = body, 3 = tail, 0 = illegal.
- Head flit: dest in [DW-1:0], INDEX in [2DW-1:DW]. Body and tail flits carry the payload counter in [DATA_WIDTH-TYPE_WIDTH-1:0].
- Payload counter: starts at 0, increments on each accepted body or tail flit, and wraps modulo 2^(DATA_WIDTH-TYPE_WIDTH).
- Handshake: a transfer occurs on a posedge where valid && ready. Once valid_out is high, it and data_out stay stable until accepted.
- TX FSM states: IDLE, HEAD, BODY, TAIL, GAP.
  - IDLE: start with num_packets != 0 latches dest, num_packets and gap_cycles, then goes to HEAD. busy rises in the next cycle, together with valid_out carrying the head flit.
  - IDLE, start with num_packets == 0: stays IDLE; done pulses in the next cycle.
  - HEAD → BODY when accepted. If FlitPerPacket == 2, HEAD → TAIL instead.
  - BODY: stays for FlitPerPacket-2 accepted flits, then → TAIL.
  - TAIL accepted: tx_packets++ (wraps). If more packets remain → GAP, or → HEAD when gap_cycles == 0. Otherwise → IDLE, with busy = 0 and a done pulse in the same cycle.
  - GAP: valid_out = 0 for exactly gap_cycles cycles, then → HEAD.
  - start while busy is ignored.
  - tx_packets is cleared only by rst.
- RX FSM states: OUT, IN. ready_in = 1 when not in reset (unless the optional feature is enabled).
  - OUT, head accepted: → IN; length counter = 1. If dest field != INDEX, set err_dest (the packet is still tracked).
  - OUT, body or tail accepted: set err_frame; stay in OUT.
  - IN, body accepted: length counter++.
  - IN, tail accepted: length counter+1 is compared with FlitPerPacket. If unequal, set err_len; if equal and no error occurred during the packet, rx_packets++. Then → OUT.
  - IN, head accepted: set err_frame; restart the packet (length counter = 1).
  - Type 0 in any state: set err_frame; state unchanged.
  - rx_flits++ on every accepted flit, including erroneous ones; all counters wrap.
- clear_stats: zeroes rx_packets, rx_flits and all err_* flags. A flit accepted in the same cycle is not counted. The RX FSM state is unaffected.
- TX and RX are fully independent. Local loopback (dest == INDEX) is legal.

Optional Feature:
NOC_NODE_BACKPRESSURE_EN
- Defined: a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 + INDEX at rst) steps every cycle. ready_in = ~rst & ~(lfsr[1:0] == 2'b00), i.e. about 25% stall. RX behaviour is otherwise identical.
- Undefined: ready_in = ~rst constantly; the LFSR is absent.

Test Plan:
- Single packet to node 5, INDEX=0, ready_out=1 → flits 0x40000005, 0x80000000, …, 0xC0000004; busy high for 6 cycles; done pulses with the tail; tx_packets=1.
- ready_out toggling 1/0 each cycle, num_packets=2, gap_cycles=3 → data_out held during stalls; exactly 3 valid_out=0 cycles between packets; 12 flits in order; tx_packets=2.
- Two nodes looped into each other's RX (N=6, INDEX 4 and 5) → each rx_packets=1, rx_flits=6, all err_* = 0.
- RX input: body without head, then head, head, 4 body, tail → err_frame=1, err_len=0, rx_packets=1, rx_flits=8.
- RX input: head with dest=3 to INDEX=0, then a 5-flit packet → err_dest=1, err_len=1, rx_packets=0; then clear_stats → all flags and counters 0.
- rst asserted mid-packet (after body 2), then restarted → valid_out=0 in the next cycle; the new burst restarts from the head flit with payload 0.

Source files
------------

// File: rtl/noc_traffic_node.sv
// noc_traffic_node: NoC endpoint with a framed-packet generator on TX and a sink/checker on RX.
// Latency: the first TX flit appears one cycle after start. RX statistics update one cycle after a flit is accepted.
// Backpressure: TX holds data_out/valid_out until ready_out. RX ready_in is ~rst, or has LFSR stalls (NOC_NODE_BACKPRESSURE_EN).
//
// Ports:
//   clk, rst (sync, active-high)
//   start, dest, num_packets, gap_cycles   burst request, sampled only in IDLE
//   busy, done                             burst status; done pulses once per burst
//   data_out, valid_out, ready_out         TX flit stream into the router local port
//   data_in, valid_in, ready_in            RX flit stream from the router local port
//   clear_stats                            zeroes the RX counters and the sticky error flags
//   tx_packets, rx_packets, rx_flits       wrapping statistics counters
//   err_dest, err_frame, err_len           sticky RX error flags
// Optional macro: NOC_NODE_BACKPRESSURE_EN adds a 16-bit LFSR that throttles ready_in.
module noc_traffic_node #(
    parameter int N             = 6,
    parameter int INDEX         = 0,
    parameter int DATA_WIDTH    = 32,
    parameter int TYPE_WIDTH    = 2,
    parameter int FlitPerPacket = 6,
    parameter int COUNT_WIDTH   = 16,
    localparam int DW           = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DW-1:0]          dest,
    input  logic [COUNT_WIDTH-1:0] num_packets,
    input  logic [COUNT_WIDTH-1:0] gap_cycles,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   valid_out,
    input  logic                   ready_out,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   valid_in,
    output logic                   ready_in,
    input  logic                   clear_stats,
    output logic [COUNT_WIDTH-1:0] tx_packets,
    output logic [COUNT_WIDTH-1:0] rx_packets,
    output logic [COUNT_WIDTH-1:0] rx_flits,
    output logic                   err_dest,
    output logic                   err_frame,
    output logic                   err_len
);
    localparam int PW = DATA_WIDTH - TYPE_WIDTH;
    localparam logic [TYPE_WIDTH-1:0]  T_HEAD    = TYPE_WIDTH'(1);
    localparam logic [TYPE_WIDTH-1:0]  T_BODY    = TYPE_WIDTH'(2);
    localparam logic [TYPE_WIDTH-1:0]  T_TAIL    = TYPE_WIDTH'(3);
    localparam logic [DW-1:0]          IDX       = DW'(INDEX);
    localparam logic [COUNT_WIDTH-1:0] BODY_LAST = COUNT_WIDTH'(FlitPerPacket - 3);
    localparam logic [COUNT_WIDTH-1:0] FPP_CNT   = COUNT_WIDTH'(FlitPerPacket);

    function automatic logic [DATA_WIDTH-1:0] head_flit(input logic [DW-1:0] d);
        logic [DATA_WIDTH-1:0] f;
        f                           = '0;
        f[DATA_WIDTH-1 -: TYPE_WIDTH] = T_HEAD;
        f[DW-1:0]                   = d;
        f[2*DW-1:DW]                = IDX;
        return f;
    endfunction

    // ---------------- TX packet generator ----------------
    typedef enum logic [2:0] {TX_IDLE, TX_HEAD, TX_BODY, TX_TAIL, TX_GAP} tx_state_t;

    tx_state_t              tx_state_q, tx_state_d;
    logic [DW-1:0]          dest_q, dest_d;
    logic [COUNT_WIDTH-1:0] rem_q, rem_d;      // packets still to send, including the current one
    logic [COUNT_WIDTH-1:0] gap_q, gap_d;
    logic [COUNT_WIDTH-1:0] gcnt_q, gcnt_d;
    logic [COUNT_WIDTH-1:0] bcnt_q, bcnt_d;
    logic [PW-1:0]          pay_q, pay_d;      // payload of the next body/tail flit
    logic [COUNT_WIDTH-1:0] txp_q, txp_d;
    logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
    logic                   valid_out_q, valid_out_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   tx_acc;

    assign tx_acc = valid_out_q & ready_out;

    always_comb begin
        tx_state_d  = tx_state_q;
        dest_d      = dest_q;
        rem_d       = rem_q;
        gap_d       = gap_q;
        gcnt_d      = gcnt_q;
        bcnt_d      = bcnt_q;
        pay_d       = pay_q;
        txp_d       = txp_q;
        data_out_d  = data_out_q;
        valid_out_d = valid_out_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (start) begin
                    if (num_packets != '0) begin
                        dest_d      = dest;
                        rem_d       = num_packets;
                        gap_d       = gap_cycles;
                        tx_state_d  = TX_HEAD;
                        busy_d      = 1'b1;
                        valid_out_d = 1'b1;
                        data_out_d  = head_flit(dest);
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            TX_HEAD: begin
                if (tx_acc) begin
                    bcnt_d = '0;
                    if (FlitPerPacket == 2) begin
                        tx_state_d = TX_TAIL;
                        data_out_d = {T_TAIL, pay_q};
                    end else begin
                        tx_state_d = TX_BODY;
                        data_out_d = {T_BODY, pay_q};
                    end
                end
            end
            TX_BODY: begin
                if (tx_acc) begin
                    pay_d = pay_q + 1'b1;
                    if (bcnt_q == BODY_LAST) begin
                        tx_state_d = TX_TAIL;
                        data_out_d = {T_TAIL, pay_d};
                    end else begin
                        bcnt_d     = bcnt_q + 1'b1;
                        data_out_d = {T_BODY, pay_d};
                    end
                end
            end
            TX_TAIL: begin
                if (tx_acc) begin
                    pay_d = pay_q + 1'b1;
                    txp_d = txp_q + 1'b1;
                    if (rem_q != COUNT_WIDTH'(1)) begin
                        rem_d = rem_q - 1'b1;
                        if (gap_q == '0) begin
                            tx_state_d = TX_HEAD;
                            data_out_d = head_flit(dest_q);
                        end else begin
                            // gcnt counts down to zero, so GAP lasts exactly gap_q cycles
                            tx_state_d  = TX_GAP;
                            gcnt_d      = gap_q - 1'b1;
                            valid_out_d = 1'b0;
                            data_out_d  = '0;
                        end
                    end else begin
                        tx_state_d  = TX_IDLE;
                        valid_out_d = 1'b0;
                        data_out_d  = '0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end
            TX_GAP: begin
                if (gcnt_q == '0) begin
                    tx_state_d  = TX_HEAD;
                    valid_out_d = 1'b1;
                    data_out_d  = head_flit(dest_q);
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q  <= TX_IDLE;
            dest_q      <= '0;
            rem_q       <= '0;
            gap_q       <= '0;
            gcnt_q      <= '0;
            bcnt_q      <= '0;
            pay_q       <= '0;
            txp_q       <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            dest_q      <= dest_d;
            rem_q       <= rem_d;
            gap_q       <= gap_d;
            gcnt_q      <= gcnt_d;
            bcnt_q      <= bcnt_d;
            pay_q       <= pay_d;
            txp_q       <= txp_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign data_out   = data_out_q;
    assign valid_out  = valid_out_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign tx_packets = txp_q;

    // ---------------- RX sink / checker ----------------
    typedef enum logic {RX_OUT, RX_IN} rx_state_t;

    rx_state_t              rx_state_q, rx_state_d;
    logic [COUNT_WIDTH-1:0] len_q, len_d;
    logic                   bad_q, bad_d;      // an error was seen inside the current packet
    logic [COUNT_WIDTH-1:0] rxp_q, rxp_d;
    logic [COUNT_WIDTH-1:0] rxf_q, rxf_d;
    logic                   err_dest_q, err_dest_d;
    logic                   err_frame_q, err_frame_d;
    logic                   err_len_q, err_len_d;
    logic                   rx_acc;
    logic [TYPE_WIDTH-1:0]  rx_typ;
    logic                   head_bad;
    logic                   set_dest, set_frame, set_len, pkt_ok;
    logic                   rx_unused;

    assign rx_acc    = valid_in & ready_in;
    assign rx_typ    = data_in[DATA_WIDTH-1 -: TYPE_WIDTH];
    assign head_bad  = data_in[DW-1:0] != IDX;
    assign rx_unused = ^data_in[PW-1:DW];

    always_comb begin
        rx_state_d  = rx_state_q;
        len_d       = len_q;
        bad_d       = bad_q;
        rxp_d       = rxp_q;
        rxf_d       = rxf_q;
        err_dest_d  = err_dest_q;
        err_frame_d = err_frame_q;
        err_len_d   = err_len_q;
        set_dest    = 1'b0;
        set_frame   = 1'b0;
        set_len     = 1'b0;
        pkt_ok      = 1'b0;
        if (rx_acc) begin
            if (rx_typ == T_HEAD) begin
                // a head inside a packet is a framing error and restarts tracking
                set_frame  = (rx_state_q == RX_IN);
                set_dest   = head_bad;
                rx_state_d = RX_IN;
                len_d      = COUNT_WIDTH'(1);
                bad_d      = head_bad;
            end else if (rx_typ == T_BODY || rx_typ == T_TAIL) begin
                if (rx_state_q == RX_OUT) begin
                    set_frame = 1'b1;
                end else if (rx_typ == T_BODY) begin
                    len_d = len_q + 1'b1;
                end else begin
                    if ((len_q + 1'b1) != FPP_CNT) begin
                        set_len = 1'b1;
                    end else begin
                        pkt_ok = ~bad_q;
                    end
                    rx_state_d = RX_OUT;
                end
            end else begin
                set_frame = 1'b1;
                bad_d     = bad_q | (rx_state_q == RX_IN);
            end
        end
        if (clear_stats) begin
            rxp_d       = '0;
            rxf_d       = '0;
            err_dest_d  = 1'b0;
            err_frame_d = 1'b0;
            err_len_d   = 1'b0;
        end else begin
            if (rx_acc) rxf_d = rxf_q + 1'b1;
            if (pkt_ok) rxp_d = rxp_q + 1'b1;
            err_dest_d  = err_dest_q | set_dest;
            err_frame_d = err_frame_q | set_frame;
            err_len_d   = err_len_q | set_len;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q  <= RX_OUT;
            len_q       <= '0;
            bad_q       <= 1'b0;
            rxp_q       <= '0;
            rxf_q       <= '0;
            err_dest_q  <= 1'b0;
            err_frame_q <= 1'b0;
            err_len_q   <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            len_q       <= len_d;
            bad_q       <= bad_d;
            rxp_q       <= rxp_d;
            rxf_q       <= rxf_d;
            err_dest_q  <= err_dest_d;
            err_frame_q <= err_frame_d;
            err_len_q   <= err_len_d;
        end
    end

    assign rx_packets = rxp_q;
    assign rx_flits   = rxf_q;
    assign err_dest   = err_dest_q;
    assign err_frame  = err_frame_q;
    assign err_len    = err_len_q;

`ifdef NOC_NODE_BACKPRESSURE_EN
    // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1; stalls RX when the low two bits are zero
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 16'hACE1 + 16'(INDEX);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign ready_in = ~rst & (lfsr_q[1:0] != 2'b00);
`else
    assign ready_in = ~rst;
`endif

endmodule

// File: tb/tb_noc_traffic_node.sv
// tb_noc_traffic_node: self-checking bench for noc_traffic_node (N=6, INDEX=0, 32-bit flits, 6 flits/packet).
// TX flit streams are compared with sequences built from the framing rules. RX statistics are compared with a table and a packet-level model.
// Local loopback is done by muxing the DUT's TX port into its own RX port.
module tb_noc_traffic_node;
    localparam int N    = 6;
    localparam int DW   = 3;
    localparam int FPP  = 6;
    localparam int CW   = 16;
    localparam logic [2:0] IDX3 = 3'd0;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, clear_stats;
    logic [DW-1:0] dest;
    logic [CW-1:0] num_packets, gap_cycles;
    logic          busy, done, valid_out, ready_out, valid_in, ready_in;
    logic [31:0]   data_out, data_in;
    logic [CW-1:0] tx_packets, rx_packets, rx_flits;
    logic          err_dest, err_frame, err_len;

    logic          lb;
    logic [31:0]   drv_data;
    logic          drv_vld, drv_rdy;

    assign data_in   = lb ? data_out  : drv_data;
    assign valid_in  = lb ? valid_out : drv_vld;
    assign ready_out = lb ? ready_in  : drv_rdy;

    noc_traffic_node #(.N(N), .INDEX(0), .DATA_WIDTH(32), .TYPE_WIDTH(2),
                       .FlitPerPacket(FPP), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .dest(dest), .num_packets(num_packets),
        .gap_cycles(gap_cycles), .busy(busy), .done(done), .data_out(data_out),
        .valid_out(valid_out), .ready_out(ready_out), .data_in(data_in), .valid_in(valid_in),
        .ready_in(ready_in), .clear_stats(clear_stats), .tx_packets(tx_packets),
        .rx_packets(rx_packets), .rx_flits(rx_flits), .err_dest(err_dest),
        .err_frame(err_frame), .err_len(err_len)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic [29:0]   m_pay;   // expected payload of the next TX body/tail flit
    logic [CW-1:0] m_txp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready_out=1, mode 1: toggles 1/0, mode 2: random ~75% ready
    task automatic run_tx(input logic [DW-1:0] d, input int np, input int gap, input int mode);
        logic [31:0] exp_q[$];
        logic [31:0] got_q[$];
        logic [1:0]  t;
        logic [31:0] prev_dat;
        logic        prev_stall, r;
        int          busy_cyc, idle_busy, done_cnt, cyc;
        for (int p = 0; p < np; p++) begin
            exp_q.push_back({2'b01, 24'd0, IDX3, d});
            for (int f = 1; f < FPP; f++) begin
                t = (f == FPP - 1) ? 2'b11 : 2'b10;
                exp_q.push_back({t, m_pay});
                m_pay = m_pay + 30'd1;
            end
        end
        m_txp = m_txp + CW'(np);
        dest = d; num_packets = CW'(np); gap_cycles = CW'(gap); start = 1'b1;
        tick;
        start = 1'b0;
        prev_stall = 1'b0; prev_dat = '0;
        busy_cyc = 0; idle_busy = 0; done_cnt = 0;
        for (cyc = 0; cyc < 2000; cyc++) begin
            // a start pulse mid-burst must be ignored
            if (cyc == 2) begin
                start = 1'b1; dest = ~d; num_packets = 16'd7;
            end else begin
                start = 1'b0;
            end
            case (mode)
                0:       drv_rdy = 1'b1;
                1:       drv_rdy = (cyc % 2 == 0);
                default: drv_rdy = ($urandom_range(0, 3) != 0);
            endcase
            r = lb ? ready_in : drv_rdy;
            if (cyc == 0) begin
                check("tx_busy_first", busy, 1);
                check("tx_valid_first", valid_out, 1);
            end
            if (prev_stall) begin
                check("tx_hold_valid", valid_out, 1);
                check("tx_hold_data", data_out, prev_dat);
            end
            if (busy) busy_cyc++;
            if (busy && !valid_out && got_q.size() > 0) idle_busy++;
            if (done) begin
                done_cnt++;
                check("tx_busy_at_done", busy, 0);
                break;
            end
            if (valid_out && r) got_q.push_back(data_out);
            prev_stall = valid_out && !r;
            prev_dat   = data_out;
            tick;
        end
        start = 1'b0;
        check("tx_done_seen", done_cnt, 1);
        check("tx_flit_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("tx_flit%0d", i), got_q[i], exp_q[i]);
        check("tx_gap_cycles", idle_busy, (np - 1) * gap);
        if (mode == 0) check("tx_busy_cycles", busy_cyc, np * FPP + (np - 1) * gap);
        check("tx_packets", tx_packets, m_txp);
        tick;
        check("tx_done_one_cycle", done, 0);
    endtask

    // RX stimulus table: one record per cycle with expected stats afterwards
    typedef struct {
        logic       clr;
        logic       vld;
        logic [1:0] typ;
        logic [2:0] dst;
        int         flits;
        int         pkts;
        logic [2:0] errs;   // {err_dest, err_frame, err_len}
    } rx_vec_t;
    rx_vec_t tbl[$];

    function automatic void addv(input logic clr, input logic vld, input logic [1:0] typ,
                                 input logic [2:0] dst, input int fl, input int pk,
                                 input logic [2:0] errs);
        rx_vec_t v;
        v.clr = clr; v.vld = vld; v.typ = typ; v.dst = dst;
        v.flits = fl; v.pkts = pk; v.errs = errs;
        tbl.push_back(v);
    endfunction

    // packet-level RX model state
    logic m_in, m_bad, m_ed, m_ef, m_el;
    int   m_len, m_fl, m_pk;

    initial begin
        logic [31:0] fq[$];
        logic [31:0] f;
        logic        v, c, sd, sf, sl, inc;
        int          len;
        logic [2:0]  dd;

        rst = 1'b1; start = 1'b0; clear_stats = 1'b0; dest = '0;
        num_packets = '0; gap_cycles = '0; lb = 1'b0;
        drv_data = '0; drv_vld = 1'b0; drv_rdy = 1'b0;
        m_pay = '0; m_txp = '0;

        // reset state
        tick; tick;
        check("rst_valid_out", valid_out, 0);
        check("rst_data_out", data_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready_in", ready_in, 0);
        check("rst_stats", {tx_packets, rx_packets}, 0);
        check("rst_rx_flits_errs", {rx_flits, err_dest, err_frame, err_len}, 0);
        rst = 1'b0;
        tick;
        check("ready_in_after_rst", ready_in, 1);

        // single packet, always ready
        run_tx(3'd5, 1, 0, 0);
        // toggling ready, two packets, three-cycle gap
        run_tx(3'd2, 2, 3, 1);
        // zero-packet burst: done pulses, nothing sent
        num_packets = '0; start = 1'b1;
        tick;
        start = 1'b0;
        check("zero_done", done, 1);
        check("zero_busy_valid", {busy, valid_out}, 0);
        tick;
        check("zero_done_clear", done, 0);
        // randomized bursts
        for (int k = 0; k < 6; k++)
            run_tx(3'($urandom_range(0, 5)), $urandom_range(1, 3), $urandom_range(0, 4), 2);

        // local loopback through our own RX
        clear_stats = 1'b1;
        tick;
        clear_stats = 1'b0;
        lb = 1'b1;
        run_tx(3'd0, 1, 0, 0);
        tick;
        lb = 1'b0;
        check("lb_rx_packets", rx_packets, 1);
        check("lb_rx_flits", rx_flits, 6);
        check("lb_errs", {err_dest, err_frame, err_len}, 0);

        // RX directed table
        addv(1, 0, 0, 0, 0, 0, 3'b000);
        addv(0, 1, 2, 0, 1, 0, 3'b010);   // body without head
        addv(0, 1, 1, 0, 2, 0, 3'b010);
        addv(0, 1, 1, 0, 3, 0, 3'b010);   // head inside packet restarts it
        for (int i = 0; i < 4; i++) addv(0, 1, 2, 0, 4 + i, 0, 3'b010);
        addv(0, 0, 1, 0, 7, 0, 3'b010);   // idle cycle
        addv(0, 1, 3, 0, 8, 1, 3'b010);
        addv(1, 0, 0, 0, 0, 0, 3'b000);
        addv(0, 1, 1, 3, 1, 0, 3'b100);   // wrong destination
        for (int i = 0; i < 3; i++) addv(0, 1, 2, 0, 2 + i, 0, 3'b100);
        addv(0, 1, 3, 0, 5, 0, 3'b101);   // 5-flit packet
        addv(0, 1, 0, 0, 6, 0, 3'b111);   // illegal type
        addv(1, 1, 1, 0, 0, 0, 3'b000);   // clear with a head accepted: not counted, FSM still enters IN
        for (int i = 0; i < 4; i++) addv(0, 1, 2, 0, 1 + i, 0, 3'b000);
        addv(0, 1, 3, 0, 5, 1, 3'b000);
        addv(0, 1, 1, 0, 6, 1, 3'b000);
        addv(0, 1, 0, 0, 7, 1, 3'b010);   // illegal type inside packet spoils it
        for (int i = 0; i < 4; i++) addv(0, 1, 2, 0, 8 + i, 1, 3'b010);
        addv(0, 1, 3, 0, 12, 1, 3'b010);
        for (int i = 0; i < tbl.size(); i++) begin
            clear_stats = tbl[i].clr;
            drv_vld     = tbl[i].vld;
            drv_data    = {tbl[i].typ, 27'd0, tbl[i].dst};
            tick;
            clear_stats = 1'b0;
            drv_vld     = 1'b0;
            check($sformatf("rxt%0d_flits", i), rx_flits, tbl[i].flits);
            check($sformatf("rxt%0d_pkts", i), rx_packets, tbl[i].pkts);
            check($sformatf("rxt%0d_errs", i), {err_dest, err_frame, err_len}, tbl[i].errs);
        end

        // randomized RX stream against the packet-level model
        clear_stats = 1'b1;
        drv_data = {2'b01, 30'd0};
        drv_vld = 1'b1;
        tick;   // leaves the RX FSM inside a packet; model starts there
        drv_vld = 1'b0; clear_stats = 1'b0;
        m_in = 1'b1; m_len = 1; m_bad = 1'b0;
        m_fl = 0; m_pk = 0; m_ed = 0; m_ef = 0; m_el = 0;
        for (int p = 0; p < 40; p++) begin
            len = ($urandom_range(0, 9) < 7) ? FPP : $urandom_range(2, 8);
            dd  = ($urandom_range(0, 9) < 8) ? 3'd0 : 3'($urandom_range(1, 5));
            fq.push_back({2'b01, 27'd0, dd});
            for (int k = 1; k < len; k++)
                fq.push_back({(k == len - 1) ? 2'b11 : 2'b10, 30'($urandom)});
            if ($urandom_range(0, 9) == 0) fq.push_back({2'($urandom_range(0, 3)), 30'd0});
        end
        for (int cyc = 0; cyc < 2000 && fq.size() > 0; cyc++) begin
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 29) == 0);
            f = v ? fq[0] : $urandom;
            drv_vld = v; drv_data = f; clear_stats = c;
            tick;
            drv_vld = 1'b0; clear_stats = 1'b0;
            sd = 0; sf = 0; sl = 0; inc = 0;
            if (v) begin
                void'(fq.pop_front());
                case (f[31:30])
                    2'd1: begin
                        if (m_in) sf = 1;
                        m_in = 1; m_len = 1; m_bad = (f[2:0] != IDX3); sd = m_bad;
                    end
                    2'd2: if (!m_in) sf = 1; else m_len++;
                    2'd3: begin
                        if (!m_in) sf = 1;
                        else begin
                            if (m_len + 1 != FPP) sl = 1; else if (!m_bad) inc = 1;
                            m_in = 0;
                        end
                    end
                    default: begin sf = 1; if (m_in) m_bad = 1; end
                endcase
            end
            if (c) begin
                m_fl = 0; m_pk = 0; m_ed = 0; m_ef = 0; m_el = 0;
            end else begin
                if (v) m_fl++;
                if (inc) m_pk++;
                m_ed |= sd; m_ef |= sf; m_el |= sl;
            end
            check("rxr_flits", rx_flits, CW'(m_fl));
            check("rxr_pkts", rx_packets, CW'(m_pk));
            check("rxr_errs", {err_dest, err_frame, err_len}, {m_ed, m_ef, m_el});
        end
        check("rxr_stream_drained", fq.size(), 0);

        // reset in the middle of a packet, then a fresh burst
        dest = 3'd2; num_packets = 16'd1; gap_cycles = '0; start = 1'b1; drv_rdy = 1'b1;
        tick;
        start = 1'b0;
        tick; tick; tick;
        check("mid_valid_before_rst", valid_out, 1);
        rst = 1'b1;
        tick;
        check("mid_rst_valid", valid_out, 0);
        check("mid_rst_data", data_out, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready_in", ready_in, 0);
        check("mid_rst_stats", {rx_flits, rx_packets}, 0);
        rst = 1'b0;
        m_pay = '0; m_txp = '0;
        tick;
        run_tx(3'd2, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
